// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access modes, FSM states,
// and the lane/byte-enable rules that are common to loads and stores.
package lsu_pkg;

  localparam logic [2:0] ACC_B    = 3'b000;
  localparam logic [2:0] ACC_H    = 3'b001;
  localparam logic [2:0] ACC_W    = 3'b010;
  localparam logic [2:0] ACC_BU   = 3'b011;
  localparam logic [2:0] ACC_HU   = 3'b100;
  localparam logic [2:0] ACC_NONE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Loads accept every sized mode; stores have no unsigned variants.
  function automatic logic mode_valid(input logic [2:0] mode, input logic is_wr);
    logic ok;
    if (is_wr) begin
      ok = (mode <= ACC_W);
    end else begin
      ok = (mode <= ACC_HU);
    end
    return ok;
  endfunction

  function automatic logic is_aligned(input logic [2:0] mode, input logic [1:0] lo);
    logic ok;
    case (mode)
      ACC_H, ACC_HU: ok = (lo[0] == 1'b0);
      ACC_W:         ok = (lo == 2'b00);
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] mode, input logic [1:0] lo);
    logic [3:0] be;
    case (mode)
      ACC_B, ACC_BU: be = 4'b0001 << lo;
      ACC_H, ACC_HU: be = lo[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand into every lane so the byte enables alone pick the target.
  function automatic logic [31:0] store_data(input logic [2:0] mode, input logic [31:0] wd);
    logic [31:0] d;
    case (mode)
      ACC_B:   d = {4{wd[7:0]}};
      ACC_H:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Word-wide memory bus between the load/store unit (master) and the memory side (slave).
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_load_fmt.sv
// Combinational load formatter: picks the addressed byte/halfword out of the bus
// word and sign- or zero-extends it according to the access mode.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] bus_rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  mode_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection from the low address bits.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo_i)
      2'b00:   byte_s = bus_rdata_i[7:0];
      2'b01:   byte_s = bus_rdata_i[15:8];
      2'b10:   byte_s = bus_rdata_i[23:16];
      2'b11:   byte_s = bus_rdata_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = bus_rdata_i[31:16];
    end else begin
      half_s = bus_rdata_i[15:0];
    end
  end

  // Extension per access mode.
  always_comb begin
    result_o = 32'h0000_0000;
    case (mode_i)
      ACC_B:   result_o = {{24{byte_s[7]}}, byte_s};
      ACC_BU:  result_o = {24'h00_0000, byte_s};
      ACC_H:   result_o = {{16{half_s[15]}}, half_s};
      ACC_HU:  result_o = {16'h0000, half_s};
      ACC_W:   result_o = bus_rdata_i;
      default: result_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns B/H/W accesses into word-aligned bus transactions and stalls the core.
// Optional LSU_TIMEOUT_EN aborts a REQ phase after TIMEOUT_CYCLES without bus_ack.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        mem_acc_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  lsu_mem_ctrl_if.master    bus
);

  lsu_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              start_s, aligned_s, stall_s;
  logic [31:0]       load_fmt_s;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : CNT_RAW;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`endif

  lsu_load_fmt u_load_fmt (
    .bus_rdata_i (bus.bus_rdata),
    .addr_lo_i   (addr[1:0]),
    .mode_i      (mem_acc_mode),
    .result_o    (load_fmt_s)
  );

  // Request decode: a store takes priority when both enables are raised.
  always_comb begin
    if (wr_en) begin
      start_s = mode_valid(mem_acc_mode, 1'b1);
    end else begin
      start_s = rd_en & mode_valid(mem_acc_mode, 1'b0);
    end
    aligned_s = is_aligned(mem_acc_mode, addr[1:0]);
  end

  // Next-state and output logic of the IDLE/REQ/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    rdata_d     = rdata_q;
    misalign_d  = 1'b0;
    stall_s     = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = '0;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_s && aligned_s) begin
          state_d     = ST_REQ;
          stall_s     = 1'b1;
          bus_req_d   = 1'b1;
          bus_we_d    = wr_en;
          bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          bus_wdata_d = store_data(mem_acc_mode, wdata);
          bus_be_d    = byte_en(mem_acc_mode, addr[1:0]);
        end else if (start_s) begin
          misalign_d = 1'b1;
          rdata_d    = 32'h0000_0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = ST_DONE;
          if (!bus_we_q) begin
            rdata_d = load_fmt_s;
          end else begin
            rdata_d = rdata_q;
          end
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = 32'h0000_0000;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d = ST_REQ;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      rdata_q     <= 32'h0000_0000;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // REQ-phase watchdog counter and its error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // The IDLE->REQ stall is combinational, so it is masked while reset is held.
  assign stall         = stall_s & rst_n;
  assign rdata         = rdata_q;
  assign misalign      = misalign_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: loads/stores of each width, misalignment, no-ops,
// reset during REQ, and (with LSU_TIMEOUT_EN) the bus timeout.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  mem_acc_mode = 3'b111;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus_if ();

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_en        (rd_en),
    .wr_en        (wr_en),
    .mem_acc_mode (mem_acc_mode),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misalign     (misalign),
    .bus_err      (bus_err),
    .bus          (bus_if.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one access, acknowledge after wait_n REQ cycles, count stall cycles,
  // and capture the bus request as seen in the first REQ cycle.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rbus, input int wait_n,
                            output int stall_cnt, output logic [31:0] c_addr,
                            output logic [31:0] c_wdata, output logic [3:0] c_be,
                            output logic c_we);
    int req_n;
    rd_en = rd; wr_en = wr; mem_acc_mode = m; addr = a; wdata = wd;
    bus_if.bus_rdata = rbus;
    #1;
    stall_cnt = 0; req_n = 0;
    c_addr = 32'h0; c_wdata = 32'h0; c_be = 4'h0; c_we = 1'b0;
    for (int i = 0; i < 60 && stall; i++) begin
      stall_cnt++;
      if (bus_if.bus_req) begin
        req_n++;
        if (req_n == 1) begin
          c_addr = bus_if.bus_addr; c_wdata = bus_if.bus_wdata;
          c_be = bus_if.bus_be; c_we = bus_if.bus_we;
        end
      end
      bus_if.bus_ack = bus_if.bus_req && (req_n > wait_n);
      step();
    end
    bus_if.bus_ack = 1'b0;
    check_val({tag, "_stall_released"}, {31'h0, stall}, 32'h0);
  endtask

  task automatic release_core();
    rd_en = 1'b0; wr_en = 1'b0; mem_acc_mode = 3'b111;
    step();
  endtask

  int          sc;
  logic [31:0] ca, cw;
  logic [3:0]  cb;
  logic        cwe;

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rdata = 32'h0;
    step(); step();
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_stall", {31'h0, stall}, 32'h0);
    check_val("rst_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
    check_val("rst_bus_be", {28'h0, bus_if.bus_be}, 32'h0);
    check_val("rst_bus_err", {31'h0, bus_err}, 32'h0);
    rst_n = 1'b1;
    step();

    // LB 0x103, ack in first REQ cycle
    run_access("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, sc, ca, cw, cb, cwe);
    check_val("lb_stall", sc, 32'd2);
    check_val("lb_addr", ca, 32'h100);
    check_val("lb_be", {28'h0, cb}, 32'h8);
    check_val("lb_we", {31'h0, cwe}, 32'h0);
    check_val("lb_rdata", rdata, 32'hFFFF_FF80);
    check_val("lb_req_drop", {31'h0, bus_if.bus_req}, 32'h0);
    release_core();

    // LHU 0x102, three wait cycles
    run_access("lhu", 1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'hBEEF_0000, 3, sc, ca, cw, cb, cwe);
    check_val("lhu_stall", sc, 32'd5);
    check_val("lhu_be", {28'h0, cb}, 32'hC);
    check_val("lhu_rdata", rdata, 32'h0000_BEEF);
    release_core();

    // SB 0x201
    run_access("sb", 1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00AB, 32'h0, 0, sc, ca, cw, cb, cwe);
    check_val("sb_stall", sc, 32'd2);
    check_val("sb_we", {31'h0, cwe}, 32'h1);
    check_val("sb_addr", ca, 32'h200);
    check_val("sb_wdata", cw, 32'hABAB_ABAB);
    check_val("sb_be", {28'h0, cb}, 32'h2);
    check_val("sb_rdata_kept", rdata, 32'h0000_BEEF);
    release_core();

    // LH 0x100, negative halfword
    run_access("lh", 1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h0000_8001, 0, sc, ca, cw, cb, cwe);
    check_val("lh_be", {28'h0, cb}, 32'h3);
    check_val("lh_rdata", rdata, 32'hFFFF_8001);
    release_core();

    // LBU 0x101, one wait cycle
    run_access("lbu", 1'b1, 1'b0, 3'b011, 32'h101, 32'h0, 32'h0000_F000, 1, sc, ca, cw, cb, cwe);
    check_val("lbu_stall", sc, 32'd3);
    check_val("lbu_be", {28'h0, cb}, 32'h2);
    check_val("lbu_rdata", rdata, 32'h0000_00F0);
    release_core();

    // SH 0x102
    run_access("sh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_CAFE, 32'h0, 0, sc, ca, cw, cb, cwe);
    check_val("sh_wdata", cw, 32'hCAFE_CAFE);
    check_val("sh_be", {28'h0, cb}, 32'hC);
    check_val("sh_rdata_kept", rdata, 32'h0000_00F0);
    release_core();

    // LW 0x204
    run_access("lw", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h1234_5678, 0, sc, ca, cw, cb, cwe);
    check_val("lw_addr", ca, 32'h204);
    check_val("lw_be", {28'h0, cb}, 32'hF);
    check_val("lw_rdata", rdata, 32'h1234_5678);
    release_core();

    // Both enables: the store wins
    run_access("both", 1'b1, 1'b1, 3'b010, 32'h208, 32'hDEAD_BEEF, 32'h0, 0, sc, ca, cw, cb, cwe);
    check_val("both_we", {31'h0, cwe}, 32'h1);
    check_val("both_wdata", cw, 32'hDEAD_BEEF);
    check_val("both_rdata_kept", rdata, 32'h1234_5678);
    release_core();

    // Invalid load mode 101: no-op
    run_access("inv_ld", 1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h0, 0, sc, ca, cw, cb, cwe);
    step();
    check_val("inv_ld_req", {31'h0, bus_if.bus_req}, 32'h0);
    check_val("inv_ld_misalign", {31'h0, misalign}, 32'h0);
    check_val("inv_ld_rdata", rdata, 32'h1234_5678);
    release_core();

    // Unsigned mode is not a store: no-op
    run_access("inv_st", 1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, sc, ca, cw, cb, cwe);
    step();
    check_val("inv_st_req", {31'h0, bus_if.bus_req}, 32'h0);
    release_core();

    // SW 0x102: misaligned
    run_access("sw_mis", 1'b0, 1'b1, 3'b010, 32'h102, 32'h1111_2222, 32'h0, 0, sc, ca, cw, cb, cwe);
    check_val("sw_mis_stall", sc, 32'd0);
    step();
    check_val("sw_mis_pulse", {31'h0, misalign}, 32'h1);
    check_val("sw_mis_req", {31'h0, bus_if.bus_req}, 32'h0);
    check_val("sw_mis_rdata", rdata, 32'h0);
    release_core();
    check_val("sw_mis_pulse_end", {31'h0, misalign}, 32'h0);

    // Stray ack in IDLE
    bus_if.bus_rdata = 32'hFFFF_FFFF;
    bus_if.bus_ack = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;
    check_val("stray_ack_req", {31'h0, bus_if.bus_req}, 32'h0);
    check_val("stray_ack_rdata", rdata, 32'h0);

    // Reset while in REQ, load still asserted
    rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h300;
    step();
    check_val("rstreq_in_req", {31'h0, bus_if.bus_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("rstreq_req", {31'h0, bus_if.bus_req}, 32'h0);
    check_val("rstreq_stall", {31'h0, stall}, 32'h0);
    rd_en = 1'b0;
    bus_if.bus_ack = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    bus_if.bus_ack = 1'b0;
    check_val("rstreq_after_req", {31'h0, bus_if.bus_req}, 32'h0);
    check_val("rstreq_after_stall", {31'h0, stall}, 32'h0);
    check_val("rstreq_after_rdata", rdata, 32'h0);

`ifdef LSU_TIMEOUT_EN
    run_access("pre_to", 1'b1, 1'b0, 3'b010, 32'h304, 32'h0, 32'h55AA_55AA, 0, sc, ca, cw, cb, cwe);
    check_val("pre_to_rdata", rdata, 32'h55AA_55AA);
    release_core();
    run_access("to", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1000, sc, ca, cw, cb, cwe);
    check_val("to_stall", sc, 32'd5);
    check_val("to_bus_err", {31'h0, bus_err}, 32'h1);
    check_val("to_rdata", rdata, 32'h0);
    check_val("to_req", {31'h0, bus_if.bus_req}, 32'h0);
    release_core();
    check_val("to_bus_err_end", {31'h0, bus_err}, 32'h0);
    check_val("to_idle_stall", {31'h0, stall}, 32'h0);
`else
    check_val("no_to_bus_err", {31'h0, bus_err}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit on the responder side of the decoder's memory control signals (rd_en, wr_en, mem_acc_mode).
- Turns byte, halfword and word accesses into word-aligned bus transactions with byte enables.
- Holds the core with stall while the bus is busy.
- Returns sign- or zero-extended load data for writeback.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT_CYCLES, 255, REQ-state cycles before abort (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
rd_en  in  1  load request from decoder
wr_en  in  1  store request from decoder
mem_acc_mode  in  3  000 B, 001 H, 010 W, 011 BU, 100 HU, others none
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data (rs2)
rdata  out  32  extended load data, valid in DONE
stall  out  1  freezes the core
misalign  out  1  one-cycle pulse on a misaligned access
bus_err  out  1  one-cycle pulse on timeout (LSU_TIMEOUT_EN only, else tied 0)
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word address, bits [1:0] = 0
bus_wdata  out  32  lane-replicated store data
bus_be  out  4  byte enables
bus_ack  in  1  transaction complete
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset asserted mid-transaction aborts to IDLE immediately and drops bus_req.
- Access start: start = (rd_en | wr_en) & valid mode. Valid modes are 000–100 for loads and 000–010 for stores.
- Invalid mode, or no enable: no-op; stall = 0; rdata unchanged.
- Both enables asserted: wr_en wins.
- Alignment: H/HU require addr[0] = 0; W requires addr[1:0] = 0.
- Misaligned access: no bus transaction, misalign = 1 for one cycle, stall = 0, rdata = 0.
- FSM states: IDLE, REQ, DONE.
  - IDLE -> REQ on an aligned start. In that cycle stall = 1 (combinational), and bus_req/bus_we/bus_addr/bus_wdata/bus_be are registered.
  - REQ: bus_req = 1, stall = 1, bus outputs held stable. On bus_ack, format bus_rdata into rdata (loads only; stores leave rdata unchanged), drop bus_req, go to DONE.
  - DONE: stall = 0, rdata valid; rd_en/wr_en are ignored (they still belong to the completing instruction). Always returns to IDLE next cycle.
- Latency: with bus_ack in the first REQ cycle, stall is high for 2 cycles; each bus wait cycle adds 1.
- Core obligation: the core holds addr, wdata, mode and the enables stable while stall = 1.
- bus_ack outside REQ is ignored.
- Stores (lane select k = addr[1:0]):
  - B: bus_wdata = {4{wdata[7:0]}}, bus_be = 0001 << k.
  - H: bus_wdata = {2{wdata[15:0]}}, bus_be = addr[1] ? 1100 : 0011.
  - W: bus_wdata = wdata, bus_be = 1111.
- Loads: bus_be follows the same rules; select byte k or halfword addr[1]. B/H sign-extend, BU/HU zero-extend, W passes through.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8-bit+ counter runs in REQ. When it reaches TIMEOUT_CYCLES without bus_ack: drop bus_req, pulse bus_err, set rdata = 0, go to DONE.
- Undefined: no counter, REQ waits indefinitely, bus_err tied 0.

Decomposition:
- Package lsu_pkg:
  - mem_acc_mode encodings as named constants (ACC_B, ACC_H, ACC_W, ACC_BU, ACC_HU, ACC_NONE = 111).
  - FSM state enum.
- One sub-module: lsu_load_fmt, a combinational extractor/extender taking bus_rdata, addr[1:0] and mode, producing the 32-bit result.

Test Plan:
- LB at addr 0x103, bus_rdata 0x80FF_1234 with ack in 1st REQ cycle -> bus_addr 0x100, bus_be 1000, stall high 2 cycles, rdata 0xFFFF_FF80.
- LHU at 0x102, bus_rdata 0xBEEF_0000, ack after 3 wait cycles -> bus_be 1100, stall high 5 cycles, rdata 0x0000_BEEF.
- SB at 0x201 with wdata 0x0000_00AB -> bus_we 1, bus_wdata 0xABAB_ABAB, bus_be 0010, rdata unchanged.
- SW at 0x102 -> misalign pulse, no bus_req, stall 0.
- rst_n low while in REQ -> bus_req 0 and stall 0 immediately; a later bus_ack is ignored.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no ack -> bus_err pulse after 4 REQ cycles, rdata 0, FSM returns to IDLE.
